// File: rtl/processor_pkg.sv
// Shared processor definitions used by the instruction memory and its controller.
package processor_pkg;

    typedef enum logic [1:0] {
        IM_CLEAR = 2'd0,
        IM_LOAD  = 2'd1,
        IM_RUN   = 2'd2
    } im_state_t;

    // Word returned for a misaligned or out-of-range fetch.
    localparam logic [31:0] IM_FAULT_INSTR = 32'h0000_0000;

    function automatic int im_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Single-port synchronous instruction RAM with registered read data.
module instr_mem_array
    import processor_pkg::*;
#(
    parameter int    DEPTH     = 128,
    parameter int    WIDTH     = 32,
    parameter string INIT_FILE = ""
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [im_addr_w(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Loadable fetch-stage instruction memory: clear/load/run sequencer, fetch handshake
// with stall hold and fault reporting, in front of a single-port RAM.
module instr_mem_ctrl
    import processor_pkg::*;
#(
    parameter int    DEPTH          = 128,
    parameter int    WIDTH          = 32,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = ""
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        FetchReq,
    input  logic [31:0]                 PC,
    input  logic                        Stall,
    output logic [WIDTH-1:0]            Instr,
    output logic                        FetchValid,
    output logic                        FetchFault,
    output logic                        Ready,
    input  logic                        LoadValid,
    input  logic [im_addr_w(DEPTH)-1:0] LoadAddr,
    input  logic [WIDTH-1:0]            LoadData,
    input  logic                        LoadLast,
    output logic                        LoadReady,
    input  logic                        Reload
);

    localparam int        AW    = im_addr_w(DEPTH);
    localparam im_state_t ENTRY = CLEAR_ON_RESET ? IM_CLEAR : IM_LOAD;

    im_state_t        state;
    logic [AW-1:0]    clr_idx;
    logic             load_fire;
    logic             fetch_fire;
    logic             fetch_fault;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;
    logic             take_p1;
    logic [WIDTH-1:0] hold_p1;
    logic             vld_p1;
    logic             fault_p1;

    // The array port is shared: CLEAR and LOAD own it for writes, RUN for reads.
    always_comb begin
        load_fire   = LoadValid && LoadReady;
        fetch_fire  = FetchReq && Ready && !Stall;
        fetch_fault = (PC[1:0] != 2'b00) || (PC[31:2] >= 30'(DEPTH));
        ram_we      = (state == IM_CLEAR) || load_fire;
        ram_wdata   = (state == IM_CLEAR) ? '0 : LoadData;
        if (state == IM_CLEAR)     ram_addr = clr_idx;
        else if (state == IM_LOAD) ram_addr = LoadAddr;
        else                       ram_addr = PC[AW+1:2];
    end

    instr_mem_array #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk  (CLK),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ENTRY;
            clr_idx   <= '0;
            Ready     <= 1'b0;
            LoadReady <= 1'b0;
        end else begin
            case (state)
                IM_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (&clr_idx) begin
                        state     <= IM_LOAD;
                        LoadReady <= 1'b1;
                    end
                end
                IM_LOAD: begin
                    if (load_fire && LoadLast) begin
                        state     <= IM_RUN;
                        Ready     <= 1'b1;
                        LoadReady <= 1'b0;
                    end else begin
                        LoadReady <= 1'b1;
                    end
                end
                IM_RUN: begin
                    if (Reload) begin
                        state     <= IM_LOAD;
                        Ready     <= 1'b0;
                        LoadReady <= 1'b1;
                    end
                end
                default: begin
                    state     <= ENTRY;
                    Ready     <= 1'b0;
                    LoadReady <= 1'b0;
                end
            endcase
        end
    end

    // ---- fetch stage p1: RAM data is used directly only on the cycle after a good
    // fetch; every other cycle replays hold_p1, which is how Stall and idle cycles hold.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            take_p1  <= 1'b0;
            hold_p1  <= '0;
            vld_p1   <= 1'b0;
            fault_p1 <= 1'b0;
        end else if (Stall) begin
            take_p1 <= 1'b0;
            hold_p1 <= Instr;
        end else begin
            take_p1 <= fetch_fire && !fetch_fault;
            hold_p1 <= (fetch_fire && fetch_fault) ? WIDTH'(IM_FAULT_INSTR) : Instr;
            vld_p1  <= fetch_fire;
            if (fetch_fire) fault_p1 <= fetch_fault;
        end
    end

    assign Instr      = take_p1 ? ram_rdata : hold_p1;
    assign FetchValid = vld_p1;
    assign FetchFault = fault_p1;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Randomized scoreboard bench for instr_mem_ctrl against a word-array reference model.
module tb_instr_mem_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          fetch_req;
    logic [31:0]   pc;
    logic          stall;
    logic [31:0]   instr;
    logic          fetch_valid;
    logic          fetch_fault;
    logic          ready;
    logic          load_valid;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          reload;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [DEPTH];
    exp_t        q [$];
    exp_t        mon_e;
    logic        stall_s;
    logic [31:0] h_instr;
    logic        h_fault;
    logic        h_valid;

    instr_mem_ctrl #(
        .DEPTH         (DEPTH),
        .WIDTH         (32),
        .CLEAR_ON_RESET(1'b1),
        .INIT_FILE     ("")
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .FetchReq  (fetch_req),
        .PC        (pc),
        .Stall     (stall),
        .Instr     (instr),
        .FetchValid(fetch_valid),
        .FetchFault(fetch_fault),
        .Ready     (ready),
        .LoadValid (load_valid),
        .LoadAddr  (load_addr),
        .LoadData  (load_data),
        .LoadLast  (load_last),
        .LoadReady (load_ready),
        .Reload    (reload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: a fetch faults when misaligned or beyond the array, else returns the stored word.
    function automatic exp_t model(input logic [31:0] a);
        exp_t e;
        e.fault = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
        e.instr = e.fault ? 32'h0 : mdl[a >> 2];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch1(input logic [31:0] a);
        fetch_req = 1'b1;
        pc        = a;
        q.push_back(model(a));
        step();
        fetch_req = 1'b0;
    endtask

    task automatic beat(input int a, input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_addr  = AW'(a);
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        mdl[a]     = d;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!load_ready && n < 2 * DEPTH + 4);
        chk(name, 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_fvalid"}, 32'(fetch_valid), 32'h0);
        chk({tag, "_ffault"}, 32'(fetch_fault), 32'h0);
        chk({tag, "_ready"}, 32'(ready), 32'h0);
        chk({tag, "_lready"}, 32'(load_ready), 32'h0);
    endtask

    // Monitor: stall cycles must replay the last result; otherwise each valid result is scored.
    always @(posedge clk) stall_s <= stall;

    always @(negedge clk) begin
        if (!rst_n) begin
            h_instr = 32'h0;
            h_fault = 1'b0;
            h_valid = 1'b0;
        end else if (stall_s) begin
            chk("hold_instr", instr, h_instr);
            chk("hold_valid", 32'(fetch_valid), 32'(h_valid));
            chk("hold_fault", 32'(fetch_fault), 32'(h_fault));
        end else if (fetch_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch actual=%h required=none", instr);
            end else begin
                mon_e = q.pop_front();
                chk("fetch_instr", instr, mon_e.instr);
                chk("fetch_fault", 32'(fetch_fault), 32'(mon_e.fault));
                h_instr = mon_e.instr;
                h_fault = mon_e.fault;
                h_valid = 1'b1;
            end
        end else begin
            h_valid = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int ord [DEPTH];
        int j, t, r;
        logic [31:0] a;

        rst_n = 1'b0; fetch_req = 1'b0; pc = '0; stall = 1'b0; reload = 1'b0;
        load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
        repeat (3) step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        wait_clear("clear_len");

        beat(0, 32'hE59F11FC, 1'b1);
        chk("run_ready", 32'(ready), 32'h1);
        chk("run_lready", 32'(load_ready), 32'h0);
        fetch1(32'h3C);
        step();

        // Reload with a fetch accepted in the same cycle; the next fetch is gated.
        reload = 1'b1;
        fetch1(32'h0);
        reload = 1'b0;
        chk("reload_ready", 32'(ready), 32'h0);
        chk("reload_lready", 32'(load_ready), 32'h1);
        fetch_req = 1'b1; pc = 32'h4;
        step();
        fetch_req = 1'b0;
        chk("gated_fvalid", 32'(fetch_valid), 32'h0);

        for (int i = 0; i < DEPTH; i++) ord[i] = i;
        for (int i = DEPTH - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < DEPTH; i++) begin
            repeat ($urandom_range(0, 2)) begin
                load_addr = AW'($urandom);
                load_data = $urandom;
                step();
            end
            beat(ord[i], $urandom, 1'b0);
        end
        beat(0, 32'hE59F1208, 1'b0);
        beat(1, 32'hEE312A01, 1'b0);
        beat(2, 32'hEAFFFFFE, 1'b0);
        beat(3, 32'hE3A09000, 1'b1);
        chk("load_ready", 32'(ready), 32'h1);

        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1;
            pc        = 32'(i * 4);
            q.push_back(model(pc));
            step();
            chk("burst_fvalid", 32'(fetch_valid), 32'h1);
        end
        fetch_req = 1'b0;
        step();

        fetch1(32'h6);
        fetch1(32'h200);
        fetch1(32'h1FC);
        step();

        // Stall for three cycles while a new request is held on PC=8.
        fetch1(32'h4);
        fetch_req = 1'b1; pc = 32'h8; stall = 1'b1;
        repeat (3) begin
            step();
            chk("stall_instr", instr, 32'hEE312A01);
            chk("stall_fvalid", 32'(fetch_valid), 32'h1);
        end
        stall = 1'b0;
        q.push_back(model(32'h8));
        step();
        fetch_req = 1'b0;
        chk("unstall_instr", instr, 32'hEAFFFFFE);
        step();

        reload = 1'b1;
        step();
        reload = 1'b0;
        chk("reload2_lready", 32'(load_ready), 32'h1);
        beat(1, 32'hE2899001, 1'b1);
        fetch1(32'h4);
        step();

        // Random fetches and stalls; load beats in RUN must be ignored.
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 6) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 7) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 7)) << 2);
            else if (r == 8) a = $urandom;
            else             a = 32'(DEPTH * 4 - 4);
            fetch_req  = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            pc         = a;
            load_valid = $urandom_range(0, 1);
            load_addr  = AW'($urandom);
            load_data  = $urandom;
            if (fetch_req && !stall) q.push_back(model(a));
            step();
        end
        fetch_req = 1'b0; stall = 1'b0; load_valid = 1'b0;
        fetch1(32'h4);
        step();
        step();

        // Asynchronous reset between edges while RUN holds a nonzero word.
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("arst_run");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("arst_clr");
        chk("arst_clr_idx", 32'(dut.clr_idx), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear("reclear_len");

        beat(5, 32'h1234ABCD, 1'b1);
        fetch1(32'h0);
        fetch1(32'h14);
        step();
        step();
        chk("queue_empty", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
